// File: rtl/sobel_stream_datapath.sv
// -----------------------------------------------------------------------------
// sobel_stream_datapath
//
// Streaming 3x3 Sobel edge detector. Pixels arrive one per valid/ready
// handshake in raster order. Two line buffers hold the previous two rows, and
// a 3x3 shift window forms around each accepted pixel. Every accept that
// completes an interior window produces one registered result one cycle later.
// The result holds the centre coordinate, the gradient magnitude and an edge
// flag.
//
// Ports
//   Clk         clock; all state updates on the rising edge
//   Reset       asynchronous active-low reset
//   in_valid    DataIn is valid
//   in_ready    block can accept a pixel (= !out_valid || out_ready)
//   DataIn      unsigned pixel, raster order
//   T           unsigned edge threshold, sampled with the completing pixel
//   Mode        0: |Gx|+|Gy|, 1: max(|Gx|,|Gy|), sampled with completing pixel
//   out_valid   result valid
//   out_ready   consumer accepts the result
//   Out_Row     row of the window centre
//   Out_Column  column of the window centre
//   Mag         gradient magnitude
//   Dop         edge flag, Mag > T
//   isEnd       result is the last one of the frame
// -----------------------------------------------------------------------------
module sobel_stream_datapath #(
  parameter int PIX_W = 8,
  parameter int IMG_W = 8,
  parameter int IMG_H = 8,
  parameter int COL_W = $clog2(IMG_W),
  parameter int ROW_W = $clog2(IMG_H),
  parameter int MAG_W = PIX_W + 3
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [PIX_W-1:0] DataIn,
  input  logic [PIX_W-1:0] T,
  input  logic             Mode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ROW_W-1:0] Out_Row,
  output logic [COL_W-1:0] Out_Column,
  output logic [MAG_W-1:0] Mag,
  output logic             Dop,
  output logic             isEnd
);

  // Signed gradient width: four times the pixel range, plus sign.
  localparam int SW = PIX_W + 4;
  localparam logic [COL_W-1:0] COL_LAST = COL_W'(IMG_W - 1);
  localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(IMG_H - 1);

  // Raster position of the next pixel to be accepted.
  logic [ROW_W-1:0] r_row;
  logic [COL_W-1:0] r_col;

  // r_lb0 holds row r-1 and r_lb1 holds row r-2, both indexed by column.
  logic [PIX_W-1:0] r_lb0 [IMG_W];
  logic [PIX_W-1:0] r_lb1 [IMG_W];

  // The two older window columns per window row. The newest column comes
  // straight from the line buffers and DataIn, so the window is complete
  // in the same cycle as the accept.
  logic [PIX_W-1:0] r_win [3][2];

  logic             r_out_valid;
  logic [ROW_W-1:0] r_out_row;
  logic [COL_W-1:0] r_out_col;
  logic [MAG_W-1:0] r_mag;
  logic             r_dop;
  logic             r_is_end;

  logic             w_accept;
  logic             w_complete;
  logic [PIX_W-1:0] w_new [3];
  logic signed [SW-1:0] w_p [9];
  logic signed [SW-1:0] w_gx;
  logic signed [SW-1:0] w_gy;
  logic [MAG_W-1:0] w_abs_gx;
  logic [MAG_W-1:0] w_abs_gy;
  logic [MAG_W-1:0] w_mag;
  logic             w_dop;

  assign in_ready   = !r_out_valid || out_ready;
  assign w_accept   = in_valid && in_ready;
  // Rows 0/1 and columns 0/1 never complete a window, so stale line-buffer
  // data from the previous frame is never used.
  assign w_complete = w_accept && (r_row >= ROW_W'(2)) && (r_col >= COL_W'(2));

  assign w_new[0] = r_lb1[r_col];
  assign w_new[1] = r_lb0[r_col];
  assign w_new[2] = DataIn;

  // NOTE: every variable in a combinational block gets a value on every path
  // (defaults first). Otherwise synthesis infers a latch to hold the old value.
  always_comb begin
    for (int k = 0; k < 3; k++) begin
      w_p[3*k + 0] = $signed({4'b0000, r_win[k][0]});
      w_p[3*k + 1] = $signed({4'b0000, r_win[k][1]});
      w_p[3*k + 2] = $signed({4'b0000, w_new[k]});
    end

    w_gx = (w_p[2] + (w_p[5] <<< 1) + w_p[8]) - (w_p[0] + (w_p[3] <<< 1) + w_p[6]);
    w_gy = (w_p[6] + (w_p[7] <<< 1) + w_p[8]) - (w_p[0] + (w_p[1] <<< 1) + w_p[2]);

    // |G| is at most 4*(2^PIX_W-1), so it fits MAG_W without loss.
    w_abs_gx = w_gx[SW-1] ? MAG_W'(-w_gx) : MAG_W'(w_gx);
    w_abs_gy = w_gy[SW-1] ? MAG_W'(-w_gy) : MAG_W'(w_gy);

    if (Mode) begin
      w_mag = (w_abs_gx > w_abs_gy) ? w_abs_gx : w_abs_gy;
    end else begin
      w_mag = w_abs_gx + w_abs_gy;
    end

    w_dop = w_mag > {{(MAG_W - PIX_W){1'b0}}, T};
  end

  // NOTE: line buffers and window registers have no reset. Their contents are
  // always overwritten before they are used, and a reset would block RAM
  // inference.
  always_ff @(posedge Clk) begin
    if (w_accept) begin
      r_lb1[r_col] <= r_lb0[r_col];
      r_lb0[r_col] <= DataIn;
      for (int k = 0; k < 3; k++) begin
        r_win[k][0] <= r_win[k][1];
        r_win[k][1] <= w_new[k];
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments. All registers then
  // update together from the values present before the edge.
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      r_row       <= '0;
      r_col       <= '0;
      r_out_valid <= 1'b0;
      r_out_row   <= '0;
      r_out_col   <= '0;
      r_mag       <= '0;
      r_dop       <= 1'b0;
      r_is_end    <= 1'b0;
    end else begin
      if (w_accept) begin
        if (r_col == COL_LAST) begin
          r_col <= '0;
          r_row <= (r_row == ROW_LAST) ? '0 : r_row + ROW_W'(1);
        end else begin
          r_col <= r_col + COL_W'(1);
        end
      end

      // A new result replaces the old one even if the old one leaves on
      // this edge. Otherwise an accepted result frees the output.
      if (w_complete) begin
        r_out_valid <= 1'b1;
        r_out_row   <= r_row - ROW_W'(1);
        r_out_col   <= r_col - COL_W'(1);
        r_mag       <= w_mag;
        r_dop       <= w_dop;
        r_is_end    <= (r_row == ROW_LAST) && (r_col == COL_LAST);
      end else if (r_out_valid && out_ready) begin
        r_out_valid <= 1'b0;
      end
    end
  end

  assign out_valid  = r_out_valid;
  assign Out_Row    = r_out_row;
  assign Out_Column = r_out_col;
  assign Mag        = r_mag;
  assign Dop        = r_dop;
  assign isEnd      = r_is_end;

endmodule
